store_lane_packer: RTL and testbench

- Store-side counterpart of the immediate/data extender. It narrows 32-bit register data into byte lanes for sw/sh/sb writes to data memory, the reverse of widening narrow fields to 32 bits.
- Accepts store requests from the MEM stage over a valid/ready handshake.
- Computes the word address, replicated lane data and byte enables.
- Buffers requests in a small FIFO and drives a req/ack write port to data memory.

---
 rtl/store_pkg.sv | 23 ++
 rtl/store_lane_pack.sv | 51 +++++
 rtl/store_lane_packer.sv | 123 ++++++++++++
 tb/tb_store_lane_packer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared definitions for the store lane packer: size encodings and store-buffer entry layout.
// Entry packing is {word address, lane data, byte enables}, byte enables in the LSBs.
package store_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int BE_LSB    = 0;
  localparam int DATA_LSB  = BE_LSB + BE_W;
  localparam int WADDR_LSB = DATA_LSB + DATA_W;

  // Entry width for the default 32-bit byte address.
  localparam int ENTRY_W = (32 - 2) + DATA_W + BE_W;

  function automatic int entry_width(input int aw);
    return (aw - 2) + DATA_W + BE_W;
  endfunction

endpackage

// File: rtl/store_lane_pack.sv
// Combinational lane mapper: byte offset + size + register data -> byte enables and replicated data.
// STORE_ALIGN_CHECK_EN enables misalignment reporting; otherwise misaligned is always 0.
module store_lane_pack
  import store_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        valid_size
);

  logic misaligned_raw_s;

  // Little-endian lane selection; half stores look only at addr_lo[1]
  always_comb begin
    be               = 4'b0000;
    wdata            = 32'h0000_0000;
    misaligned_raw_s = 1'b0;
    valid_size       = 1'b1;
    case (size)
      SZ_WORD: begin
        be               = 4'b1111;
        wdata            = data;
        misaligned_raw_s = (addr_lo != 2'b00);
      end
      SZ_HALF: begin
        be               = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata            = {2{data[15:0]}};
        misaligned_raw_s = addr_lo[0];
      end
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      default: begin
        valid_size = 1'b0;
      end
    endcase
  end

`ifdef STORE_ALIGN_CHECK_EN
  assign misaligned = misaligned_raw_s;
`else
  // Offending low bits are ignored, so nothing is ever reported misaligned.
  assign misaligned = misaligned_raw_s & 1'b0;
`endif

endmodule

// File: rtl/store_lane_packer.sv
// Store buffer: packs sw/sh/sb requests into byte lanes and drains them in order over a req/ack port.
// With STORE_ALIGN_CHECK_EN misaligned half/word stores are dropped and flagged on align_err.
module store_lane_packer
  import store_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_size,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     align_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int EW = entry_width(AW);

  logic [EW-1:0] buf_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [OW-1:0] occ_r;
  logic          align_err_r;

  logic [3:0]    lane_be_s;
  logic [31:0]   lane_wdata_s;
  logic          misaligned_s;
  logic          valid_size_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic [EW-1:0] entry_s;
  logic [EW-1:0] head_s;

  store_lane_pack u_lane_pack (
    .addr_lo    (st_addr[1:0]),
    .size       (st_size),
    .data       (st_data),
    .be         (lane_be_s),
    .wdata      (lane_wdata_s),
    .misaligned (misaligned_s),
    .valid_size (valid_size_s)
  );

  // Ready depends only on registered occupancy, never on this cycle's mem_ack.
  assign st_ready  = (occ_r != OW'(DEPTH));
  assign accept_s  = st_valid && st_ready;
  assign push_s    = accept_s && valid_size_s && !misaligned_s;
  assign mem_req   = (occ_r != {OW{1'b0}});
  assign pop_s     = mem_req && mem_ack;
  assign entry_s   = {st_addr[AW-1:2], lane_wdata_s, lane_be_s};
  assign head_s    = buf_r[rd_ptr_r];
  assign occupancy = occ_r;
  assign align_err = align_err_r;

  // Buffer storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_r[i] <= {EW{1'b0}};
      end
    end else if (push_s) begin
      buf_r[wr_ptr_r] <= entry_s;
    end
  end

  // Pointers wrap naturally; occupancy distinguishes full from empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      occ_r    <= {OW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OW'(1);
        2'b01:   occ_r <= occ_r - OW'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // One-cycle pulse after a misaligned store is accepted and dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      align_err_r <= 1'b0;
    end else begin
      align_err_r <= accept_s && valid_size_s && misaligned_s;
    end
  end

  // Head entry onto the memory port, zeroed while idle
  always_comb begin
    mem_addr  = {AW{1'b0}};
    mem_wdata = 32'h0000_0000;
    mem_be    = 4'b0000;
    if (mem_req) begin
      mem_addr  = {head_s[EW-1:WADDR_LSB], 2'b00};
      mem_wdata = head_s[WADDR_LSB-1:DATA_LSB];
      mem_be    = head_s[DATA_LSB-1:BE_LSB];
    end else begin
      mem_addr  = {AW{1'b0}};
      mem_wdata = 32'h0000_0000;
      mem_be    = 4'b0000;
    end
  end

endmodule

// File: tb/tb_store_lane_packer.sv
// Scoreboard bench for store_lane_packer: directed test-plan cases then randomized traffic.
// Define STORE_ALIGN_CHECK_EN consistently for bench and RTL to exercise the alignment check.
module tb_store_lane_packer;

  localparam int DEPTH = 2;
  localparam int AW    = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [31:0]   st_addr = 32'h0;
  logic [31:0]   st_data = 32'h0;
  logic [1:0]    st_size = 2'd0;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack = 1'b0;
  logic [1:0]    occupancy;
  logic          align_err;

  exp_t sb[$];
  int   model_cnt  = 0;
  bit   align_pend = 1'b0;
  int   n_checks   = 0;
  int   n_pass     = 0;

  store_lane_packer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .occupancy (occupancy),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: lane placement from plain arithmetic on the byte offset.
  function automatic exp_t model_entry(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    exp_t e;
    int   off;
    off     = a % 4;
    e.addr  = a - off;
    e.be    = 4'h0;
    e.wdata = 32'h0;
    if (sz == 2'd0) begin
      e.be = 4'hF; e.wdata = d;
    end else if (sz == 2'd1) begin
      e.be = 4'(3 << (2 * (off / 2))); e.wdata = d[15:0] * 32'h0001_0001;
    end else begin
      e.be = 4'(1 << off); e.wdata = d[7:0] * 32'h0101_0101;
    end
    return e;
  endfunction

  function automatic bit model_misaligned(input logic [31:0] a, input logic [1:0] sz);
`ifdef STORE_ALIGN_CHECK_EN
    return (sz == 2'd0 && (a % 4) != 0) || (sz == 2'd1 && (a % 2) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive after the edge, check and advance the model at the falling edge.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic ack);
    bit rdy_exp, acc, mis, push, pop;
    @(posedge clk); #1;
    st_valid = v; st_addr = a; st_data = d; st_size = sz; mem_ack = ack;
    @(negedge clk);
    rdy_exp = (model_cnt != DEPTH);
    chk("st_ready", st_ready, rdy_exp);
    chk("occupancy", occupancy, model_cnt);
    chk("mem_req", mem_req, model_cnt != 0);
    chk("align_err", align_err, align_pend);
    acc  = v && rdy_exp;
    mis  = (sz != 2'd3) && model_misaligned(a, sz);
    push = acc && (sz != 2'd3) && !mis;
    pop  = ack && (model_cnt != 0);
    align_pend = acc && mis;
    if (push) sb.push_back(model_entry(a, d, sz));
    model_cnt = model_cnt + int'(push) - int'(pop);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; st_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    sb.delete(); model_cnt = 0; align_pend = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: the head shown on the memory port must match the oldest expected store.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL head_unexpected: got mem_req=1 expected no pending store at %0t", $time);
        end else begin
          chk("mem_addr", mem_addr, sb[0].addr);
          chk("mem_wdata", mem_wdata, sb[0].wdata);
          chk("mem_be", mem_be, sb[0].be);
          if (mem_ack) void'(sb.pop_front());
        end
      end else begin
        chk("idle_outputs", {mem_addr, mem_wdata, mem_be}, 68'h0);
      end
    end
  end

  initial begin
    do_reset();
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);

    // sb 0x1003 then ack
    cycle(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'd2, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    chk("sb_be_literal", mem_be, 4'b1000);
    chk("sb_wdata_literal", mem_wdata, 32'hA5A5_A5A5);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);

    // sh 0x2002, sw 0x3000
    cycle(1'b1, 32'h0000_2002, 32'h1234_BEEF, 2'd1, 1'b0);
    cycle(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 2'd0, 1'b0);
    chk("sh_be_literal", mem_be, 4'b1100);
    chk("sh_wdata_literal", mem_wdata, 32'hBEEF_BEEF);

    // Full: ack with valid asserted pops one, pushes none
    cycle(1'b1, 32'h0000_5000, 32'h1111_1111, 2'd0, 1'b0);
    cycle(1'b1, 32'h0000_5004, 32'h2222_2222, 2'd0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);

    // Streaming six stores with ack held high
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 32'h0000_6000 + 32'(i * 5), 32'hC0DE_0000 + 32'(i), 2'(i % 3), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Misaligned half store
    cycle(1'b1, 32'h0000_4001, 32'h0000_9876, 2'd1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);

    // Reset with buffer full
    cycle(1'b1, 32'h0000_7000, 32'h7777_7777, 2'd0, 1'b0);
    cycle(1'b1, 32'h0000_7004, 32'h8888_8888, 2'd0, 1'b0);
    do_reset();
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);

    // Reserved size
    cycle(1'b1, 32'h0000_8000, 32'hFFFF_FFFF, 2'd3, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle(1'($urandom_range(0, 9) < 7), $urandom, $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    chk("drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
